// File: rtl/reaction_score.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : reaction_score
// Converts a reaction time in ticks to milliseconds (binary and BCD), counts
// attempts and, with REACTION_SCORE_BEST_EN defined, tracks the best result.
// Rev    : 1.0 - initial release
// ============================================================================
module reaction_score #(
  parameter int TICKS_PER_MS = 50_000
) (
  input  logic        i_clk_50m,
  input  logic        i_rst_n,
  input  logic [2:0]  i_state,
  input  logic [27:0] i_ticks,
  output logic        o_busy,
  output logic        o_valid,
  output logic [13:0] o_ms,
  output logic [15:0] o_bcd,
  output logic [13:0] o_best_ms,
  output logic [15:0] o_best_bcd,
  output logic [7:0]  o_attempts
);

  localparam logic [2:0]  c_GAME_IDLE  = 3'b000;
  localparam logic [2:0]  c_GAME_VALID = 3'b100;
  localparam logic [15:0] c_DIVISOR    = 16'(TICKS_PER_MS);
  localparam logic [13:0] c_MS_MAX     = 14'd9999;
  localparam logic [4:0]  c_DIV_LAST   = 5'd27;
  localparam logic [4:0]  c_BCD_LAST   = 5'd13;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIV  = 3'd1,
    S_SAT  = 3'd2,
    S_BCD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_prev;
  logic [4:0]  r_cnt;
  logic [15:0] r_rem;
  logic [27:0] r_quo;
  logic [13:0] r_ms_sat;
  logic [13:0] r_bin;
  logic [15:0] r_bcd;
  logic [13:0] r_ms;
  logic [15:0] r_bcd_out;
  logic [7:0]  r_attempts;
  logic        r_valid;

  logic        w_trigger;
  logic [16:0] w_trial;
  logic        w_ge;
  logic [15:0] w_diff;
  logic [13:0] w_sat;
  logic [11:0] w_adj;

  function automatic logic [3:0] f_add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  assign w_trigger = (i_state == c_GAME_VALID) && (r_prev != c_GAME_VALID);

  // Restoring divide step; the remainder is always below the divisor, so the
  // 16-bit wrap-around subtraction is exact whenever the trial is large enough.
  assign w_trial = {r_rem, r_quo[27]};
  assign w_ge    = (w_trial >= {1'b0, c_DIVISOR});
  assign w_diff  = w_trial[15:0] - c_DIVISOR;

  assign w_sat   = (r_quo > {14'd0, c_MS_MAX}) ? c_MS_MAX : r_quo[13:0];

  // Thousands digit never reaches 5 before the last shift (value <= 9999).
  assign w_adj   = {f_add3(r_bcd[11:8]), f_add3(r_bcd[7:4]), f_add3(r_bcd[3:0])};

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_trigger) w_state_next = S_DIV;
      S_DIV:   if (r_cnt == c_DIV_LAST) w_state_next = S_SAT;
      S_SAT:   w_state_next = S_BCD;
      S_BCD:   if (r_cnt == c_BCD_LAST) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev     <= c_GAME_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_ms_sat   <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_ms       <= '0;
      r_bcd_out  <= '0;
      r_attempts <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_prev  <= i_state;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_quo <= i_ticks;
            r_rem <= '0;
            r_cnt <= '0;
          end
        end
        S_DIV: begin
          r_quo <= {r_quo[26:0], w_ge};
          r_rem <= w_ge ? w_diff : w_trial[15:0];
          r_cnt <= r_cnt + 5'd1;
        end
        S_SAT: begin
          r_ms_sat <= w_sat;
          r_bin    <= w_sat;
          r_bcd    <= '0;
          r_cnt    <= '0;
        end
        S_BCD: begin
          r_bcd <= {r_bcd[14:12], w_adj, r_bin[13]};
          r_bin <= {r_bin[12:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
        end
        S_DONE: begin
          r_ms      <= r_ms_sat;
          r_bcd_out <= r_bcd;
          r_valid   <= 1'b1;
          if (r_attempts != 8'hFF) r_attempts <= r_attempts + 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef REACTION_SCORE_BEST_EN
  logic [13:0] r_best_ms;
  logic [15:0] r_best_bcd;

  // Ties keep the earlier best; the first result always loads.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_best_ms  <= '0;
      r_best_bcd <= '0;
    end else if ((r_state == S_DONE) && ((r_attempts == 8'd0) || (r_ms_sat < r_best_ms))) begin
      r_best_ms  <= r_ms_sat;
      r_best_bcd <= r_bcd;
    end
  end

  assign o_best_ms  = r_best_ms;
  assign o_best_bcd = r_best_bcd;
`else
  assign o_best_ms  = '0;
  assign o_best_bcd = '0;
`endif

  assign o_busy     = (r_state != S_IDLE);
  assign o_valid    = r_valid;
  assign o_ms       = r_ms;
  assign o_bcd      = r_bcd_out;
  assign o_attempts = r_attempts;

endmodule
`default_nettype wire

// File: doc/reaction_score.md
REACTION_SCORE -- requirements
Module: reaction_score

Interface
REQ-001 SHALL have parameter TICKS_PER_MS, default 50_000, clock ticks per millisecond; legal range 1000..65535.
REQ-002 SHALL have port i_clk_50m  input  1  single system clock, all logic on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_state  input  3  game state from the reaction stage (IDLE 000, ARMED 001, LIT 010, LATE 011, EARLY 110, VALID 100).
REQ-005 SHALL have port i_ticks  input  28  reaction time in ticks, stable whenever i_state is VALID.
REQ-006 SHALL have port o_busy  output  1  conversion in progress.
REQ-007 SHALL have port o_valid  output  1  one-cycle pulse: new result on o_ms/o_bcd.
REQ-008 SHALL have port o_ms  output  14  last result, milliseconds, binary.
REQ-009 SHALL have port o_bcd  output  16  last result, 4 BCD digits, thousands in [15:12].
REQ-010 SHALL have port o_best_ms  output  14  best (smallest) result, binary.
REQ-011 SHALL have port o_best_bcd  output  16  best result, BCD.
REQ-012 SHALL have port o_attempts  output  8  count of VALID results, saturating.

Function
REQ-013 SHALL register i_state each cycle (prev); trigger = (i_state==VALID) and (prev!=VALID).
REQ-014 SHALL, on trigger in S_IDLE, capture i_ticks and enter S_DIV; trigger outside S_IDLE SHALL be ignored (no capture, no count).
REQ-015 S_DIV SHALL be a 28-iteration restoring divide of captured ticks by TICKS_PER_MS, one quotient bit per cycle, MSB first, quotient floored, remainder discarded.
REQ-016 S_SAT (1 cycle) SHALL clamp the quotient to 9999 when it exceeds 9999.
REQ-017 S_BCD SHALL run 14-cycle shift-add-3 (double dabble) conversion of the 14-bit clamped value.
REQ-018 S_DONE (1 cycle) SHALL update o_ms, o_bcd, o_attempts, best values, assert o_valid, return to S_IDLE.
REQ-019 Latency: o_valid SHALL assert exactly 44 cycles after the capture edge; next trigger accepted the cycle after S_DONE.
REQ-020 o_busy SHALL be high in S_DIV, S_SAT, S_BCD, S_DONE, low in S_IDLE.
REQ-021 o_ms/o_bcd SHALL hold their value between results.
REQ-022 o_attempts SHALL increment by 1 in S_DONE and stick at 255.
REQ-023 EARLY and LATE entries SHALL produce no result and no count.
REQ-024 Result of 0 ms (ticks < TICKS_PER_MS) SHALL be valid: o_ms=0, o_bcd=16'h0000.

Reset
REQ-025 Reset assertion SHALL, asynchronously and mid-conversion included, force S_IDLE, prev=IDLE, o_busy=0, o_valid=0, o_ms=0, o_bcd=0, o_best_ms=0, o_best_bcd=0, o_attempts=0; partial result discarded.
REQ-026 Reset deassertion SHALL take effect at a clock edge; a VALID present on i_state at the first post-reset edge SHALL trigger (prev=IDLE).

Configuration
REQ-027 Macro REACTION_SCORE_BEST_EN defined: in S_DONE, best SHALL load the new result when o_attempts was 0 or new ms < o_best_ms (equal does not update).
REQ-028 Macro REACTION_SCORE_BEST_EN undefined: best registers and compare logic SHALL be absent; o_best_ms and o_best_bcd tied to 0.

Verification
REQ-029 VALID with i_ticks=12_345_678 -> 44 cycles later o_valid pulse, o_ms=246, o_bcd=16'h0246, o_attempts=1.
REQ-030 i_ticks=28'hFFF_FFFF -> o_ms=5368, o_bcd=16'h5368; TICKS_PER_MS=1000, i_ticks=20_000_000 -> o_ms=9999, o_bcd=16'h9999.
REQ-031 Results 300, 200, 200, 450 ms (BEST_EN defined) -> o_best_ms 300,200,200,200, o_best_bcd=16'h0200; BEST_EN undefined -> o_best_* stay 0.
REQ-032 i_rst_n low 10 cycles after capture -> o_busy=0 immediately, no o_valid, all outputs 0; next VALID entry converts normally.
REQ-033 256 VALID entries interleaved with EARLY/LATE and IDLE, plus a VALID->IDLE->VALID re-entry during S_DIV -> o_attempts=255, exactly one o_valid per accepted entry, mid-conversion entry ignored.
